// File: rtl/tmds_encode_nch.sv
// tmds_encode_nch: multi-lane TMDS symbol encoder (DVI 1.0 video coding,
// control codes, guard bands and optional TERC4 data islands).
// Two-stage pipeline: stage 1 builds the transition-minimised word q_m,
// stage 2 applies per-lane DC balancing and selects the final symbol.
// Optional feature macro: TMDS_ENCODE_NCH_TERC4_EN compiles in data island
// (TERC4) mode; without it, in_mode 3 is encoded as a control period.
// Each lane's running disparity lives in its out_disparity register, so
// the lanes share nothing except the mode field.
module tmds_encode_nch #(
  parameter int CHANNELS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              in_mode,
  input  logic [CHANNELS*8-1:0]   in_d,
  input  logic [CHANNELS*2-1:0]   in_c,
  input  logic [CHANNELS*4-1:0]   in_aux,
  output logic [CHANNELS*10-1:0]  out_d,
  output logic [CHANNELS*5-1:0]   out_disparity
);

  localparam logic [1:0] MODE_CTL = 2'd0;
  localparam logic [1:0] MODE_VID = 2'd1;
  localparam logic [1:0] MODE_GB  = 2'd2;
  localparam logic [1:0] MODE_ISL = 2'd3;

  localparam logic [9:0] CTL_00  = 10'b1101010100;
  localparam logic [9:0] CTL_01  = 10'b0010101011;
  localparam logic [9:0] CTL_10  = 10'b0101010100;
  localparam logic [9:0] CTL_11  = 10'b1010101011;
  localparam logic [9:0] GB_EVEN = 10'b1011001100;
  localparam logic [9:0] GB_ODD  = 10'b0100110011;

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    case (c)
      2'b00:   ctl_sym = CTL_00;
      2'b01:   ctl_sym = CTL_01;
      2'b10:   ctl_sym = CTL_10;
      default: ctl_sym = CTL_11;
    endcase
  endfunction

`ifdef TMDS_ENCODE_NCH_TERC4_EN
  function automatic logic [9:0] terc4_sym(input logic [3:0] n);
    case (n)
      4'h0:    terc4_sym = 10'b1010011100;
      4'h1:    terc4_sym = 10'b1001100011;
      4'h2:    terc4_sym = 10'b1011100100;
      4'h3:    terc4_sym = 10'b1011100010;
      4'h4:    terc4_sym = 10'b0101110001;
      4'h5:    terc4_sym = 10'b0100011110;
      4'h6:    terc4_sym = 10'b0110001110;
      4'h7:    terc4_sym = 10'b0100111100;
      4'h8:    terc4_sym = 10'b1011001100;
      4'h9:    terc4_sym = 10'b0100111001;
      4'hA:    terc4_sym = 10'b0110011100;
      4'hB:    terc4_sym = 10'b1011000110;
      4'hC:    terc4_sym = 10'b1010001110;
      4'hD:    terc4_sym = 10'b1001110001;
      4'hE:    terc4_sym = 10'b0101100011;
      default: terc4_sym = 10'b1011000011;
    endcase
  endfunction
`endif

  // Stage 1 registers
  logic [1:0]              mode_d,  mode_q;
  logic [CHANNELS*9-1:0]   qm_d,    qm_q;
  logic [CHANNELS*4-1:0]   ones_d,  ones_q;
  logic [CHANNELS*2-1:0]   c_d,     c_q;
`ifdef TMDS_ENCODE_NCH_TERC4_EN
  logic [CHANNELS*4-1:0]   aux_d,   aux_q;
`else
  logic                    aux_unused;
  assign aux_unused = ^in_aux;
`endif

  // Stage 2 registers (disp_q doubles as the running disparity counter)
  logic [CHANNELS*10-1:0]  out_d_d, out_d_q;
  logic [CHANNELS*5-1:0]   disp_d,  disp_q;

  // Stage 1: per-lane transition minimisation and ones count of q_m[7:0].
  always_comb begin
    logic [7:0] d;
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    d        = '0;
    n1       = '0;
    use_xnor = 1'b0;
    qm       = '0;
    qm_d     = '0;
    ones_d   = '0;
`ifdef TMDS_ENCODE_NCH_TERC4_EN
    mode_d   = in_mode;
    aux_d    = in_aux;
`else
    mode_d   = (in_mode == MODE_ISL) ? MODE_CTL : in_mode;
`endif
    c_d      = in_c;
    for (int k = 0; k < CHANNELS; k++) begin
      d        = in_d[8*k +: 8];
      n1       = 4'($countones(d));
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) begin
        qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      end
      qm[8]              = ~use_xnor;
      qm_d[9*k +: 9]     = qm;
      ones_d[4*k +: 4]   = 4'($countones(qm[7:0]));
    end
  end

  // Stage 2: DC balancing for video, fixed code selection otherwise.
  always_comb begin
    logic [8:0]        qm;
    logic [9:0]        sym;
    logic signed [6:0] ones, zeros, cnt, cnt_n;
    qm      = '0;
    sym     = CTL_00;
    ones    = '0;
    zeros   = '0;
    cnt     = '0;
    cnt_n   = '0;
    out_d_d = '0;
    disp_d  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      qm    = qm_q[9*k +: 9];
      ones  = signed'({3'b000, ones_q[4*k +: 4]});
      zeros = 7'sd8 - ones;
      cnt   = signed'({{2{disp_q[5*k+4]}}, disp_q[5*k +: 5]});
      cnt_n = '0;
      case (mode_q)
        MODE_VID: begin
          if ((cnt == 7'sd0) || (ones == zeros)) begin
            sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_n = qm[8] ? (cnt + ones - zeros) : (cnt + zeros - ones);
          end else if (((cnt > 7'sd0) && (ones > zeros)) ||
                       ((cnt < 7'sd0) && (zeros > ones))) begin
            sym   = {1'b1, qm[8], ~qm[7:0]};
            cnt_n = cnt + (qm[8] ? 7'sd2 : 7'sd0) + zeros - ones;
          end else begin
            sym   = {1'b0, qm[8], qm[7:0]};
            cnt_n = cnt - (qm[8] ? 7'sd0 : 7'sd2) + ones - zeros;
          end
          // The balancing rules keep cnt inside +/-10; saturate rather
          // than ever letting the 5-bit register wrap.
          if (cnt_n > 7'sd10) begin
            cnt_n = 7'sd10;
          end else if (cnt_n < -7'sd10) begin
            cnt_n = -7'sd10;
          end
        end
        MODE_GB: sym = ((k % 2) == 0) ? GB_EVEN : GB_ODD;
`ifdef TMDS_ENCODE_NCH_TERC4_EN
        MODE_ISL: sym = terc4_sym(aux_q[4*k +: 4]);
`endif
        default: sym = ctl_sym(c_q[2*k +: 2]);
      endcase
      out_d_d[10*k +: 10] = sym;
      disp_d[5*k +: 5]    = cnt_n[4:0];
    end
  end

  // Pipeline registers; reset flushes both stages to a control-00 symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_CTL;
      qm_q    <= '0;
      ones_q  <= '0;
      c_q     <= '0;
`ifdef TMDS_ENCODE_NCH_TERC4_EN
      aux_q   <= '0;
`endif
      out_d_q <= {CHANNELS{CTL_00}};
      disp_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      qm_q    <= qm_d;
      ones_q  <= ones_d;
      c_q     <= c_d;
`ifdef TMDS_ENCODE_NCH_TERC4_EN
      aux_q   <= aux_d;
`endif
      out_d_q <= out_d_d;
      disp_q  <= disp_d;
    end
  end

  assign out_d         = out_d_q;
  assign out_disparity = disp_q;

endmodule

// File: tb/tb_tmds_encode_nch.sv
// Bench for tmds_encode_nch with four lanes: constant vectors, a mid-video
// reset sequence and a randomized run checked against a behavioural model.
module tb_tmds_encode_nch;
  localparam int CH = 4;
  localparam int W  = CH * 15;
  localparam logic [W-1:0] RST_EXP = {{(CH*5){1'b0}}, {CH{10'b1101010100}}};

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         in_mode = '0;
  logic [CH*8-1:0]    in_d = '0;
  logic [CH*2-1:0]    in_c = '0;
  logic [CH*4-1:0]    in_aux = '0;
  logic [CH*10-1:0]   out_d;
  logic [CH*5-1:0]    out_disparity;

  tmds_encode_nch #(.CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .in_mode(in_mode), .in_d(in_d), .in_c(in_c),
    .in_aux(in_aux), .out_d(out_d), .out_disparity(out_disparity)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;
  int           mcnt[CH];

  typedef struct {
    logic [1:0] mode;
    logic [7:0] d;
    logic [1:0] c;
    logic [3:0] aux;
    logic [9:0] exp_even;
    logic [9:0] exp_odd;
    logic [4:0] exp_disp;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [9:0] ref_ctl(input logic [1:0] c);
    logic [9:0] t[4];
    t[0] = 10'b1101010100; t[1] = 10'b0010101011;
    t[2] = 10'b0101010100; t[3] = 10'b1010101011;
    return t[c];
  endfunction

  function automatic logic [9:0] ref_terc4(input logic [3:0] n);
    logic [9:0] t[16];
    t[0]  = 10'b1010011100; t[1]  = 10'b1001100011; t[2]  = 10'b1011100100;
    t[3]  = 10'b1011100010; t[4]  = 10'b0101110001; t[5]  = 10'b0100011110;
    t[6]  = 10'b0110001110; t[7]  = 10'b0100111100; t[8]  = 10'b1011001100;
    t[9]  = 10'b0100111001; t[10] = 10'b0110011100; t[11] = 10'b1011000110;
    t[12] = 10'b1010001110; t[13] = 10'b1001110001; t[14] = 10'b0101100011;
    t[15] = 10'b1011000011;
    return t[n];
  endfunction

  // Behavioural model of one lane; returns {disparity, symbol}, updates mcnt[k].
  function automatic logic [14:0] model_lane(input logic [1:0] mode, input logic [7:0] d,
                                             input logic [1:0] c, input logic [3:0] aux,
                                             input int k);
    logic [9:0] sym;
    logic [8:0] qm;
    int n1, ones, zeros, b8, cn;
    bit xn;
    sym = ref_ctl(c);
    if (mode == 2'd1) begin
      n1 = $countones(d);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      b8    = qm[8] ? 1 : 0;
      ones  = $countones(qm[7:0]);
      zeros = 8 - ones;
      if (mcnt[k] == 0 || ones == zeros) begin
        sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
        mcnt[k] = (b8 == 1) ? mcnt[k] + ones - zeros : mcnt[k] + zeros - ones;
      end else if ((mcnt[k] > 0 && ones > zeros) || (mcnt[k] < 0 && zeros > ones)) begin
        sym = {1'b1, qm[8], ~qm[7:0]};
        mcnt[k] = mcnt[k] + 2 * b8 + zeros - ones;
      end else begin
        sym = {1'b0, qm[8], qm[7:0]};
        mcnt[k] = mcnt[k] - 2 * (1 - b8) + ones - zeros;
      end
    end else begin
      mcnt[k] = 0;
      if (mode == 2'd2) sym = ((k % 2) == 0) ? 10'b1011001100 : 10'b0100110011;
`ifdef TMDS_ENCODE_NCH_TERC4_EN
      if (mode == 2'd3) sym = ref_terc4(aux);
`else
      if (mode == 2'd3) sym = ref_ctl(c);
`endif
    end
    cn = mcnt[k];
    return {cn[4:0], sym};
  endfunction

  // Driver: check the symbol due now, then drive the next one and queue its result.
  task automatic step(input logic rst, input logic [1:0] mode, input logic [CH*8-1:0] d,
                      input logic [CH*2-1:0] c, input logic [CH*4-1:0] aux,
                      input logic [W-1:0] exp, input string tag);
    logic [W-1:0] e, act;
    string t;
    @(negedge clk);
    if (exp_q.size() == 2) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      act = {out_disparity, out_d};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: out_d=%h disp=%h, expected out_d=%h disp=%h",
                 t, act[CH*10-1:0], act[W-1:CH*10], e[CH*10-1:0], e[W-1:CH*10]);
      end
    end
    reset   = rst;
    in_mode = mode;
    in_d    = d;
    in_c    = c;
    in_aux  = aux;
    if (rst) begin
      exp_q.delete();
      tag_q.delete();
      exp_q.push_back(RST_EXP); tag_q.push_back({tag, "_a"});
      exp_q.push_back(RST_EXP); tag_q.push_back({tag, "_b"});
    end else begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
  endtask

  task automatic model_step(input logic [1:0] mode, input logic [CH*8-1:0] d,
                            input logic [CH*2-1:0] c, input logic [CH*4-1:0] aux,
                            input string tag);
    logic [W-1:0] e;
    logic [14:0]  r;
    e = '0;
    for (int k = 0; k < CH; k++) begin
      r = model_lane(mode, d[8*k +: 8], c[2*k +: 2], aux[4*k +: 4], k);
      e[10*k +: 10]       = r[9:0];
      e[CH*10 + 5*k +: 5] = r[14:10];
    end
    step(1'b0, mode, d, c, aux, e, tag);
  endtask

  // Reset with random data on the inputs: reset must win.
  task automatic reset_step(input string tag);
    for (int k = 0; k < CH; k++) mcnt[k] = 0;
    step(1'b1, 2'($urandom_range(0, 3)), CH*8'($urandom()), CH*2'($urandom()),
         CH*4'($urandom()), '0, tag);
  endtask

  initial begin
    logic [W-1:0] e;
    logic [9:0]   isl_exp;
`ifdef TMDS_ENCODE_NCH_TERC4_EN
    isl_exp = 10'b1011001100;
`else
    isl_exp = 10'b1101010100;
`endif
    tbl[0]  = '{2'd0, 8'h00, 2'b01, 4'h0, 10'b0010101011, 10'b0010101011, 5'd0};
    tbl[1]  = '{2'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000, 5'b11000};
    tbl[2]  = '{2'd1, 8'h00, 2'b00, 4'h0, 10'b1111111111, 10'b1111111111, 5'b00010};
    tbl[3]  = '{2'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000, 5'b11010};
    tbl[4]  = '{2'd0, 8'h00, 2'b00, 4'h0, 10'b1101010100, 10'b1101010100, 5'd0};
    tbl[5]  = '{2'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000, 5'b11000};
    tbl[6]  = '{2'd2, 8'h00, 2'b00, 4'h0, 10'b1011001100, 10'b0100110011, 5'd0};
    tbl[7]  = '{2'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000, 5'b11000};
    tbl[8]  = '{2'd0, 8'h00, 2'b10, 4'h0, 10'b0101010100, 10'b0101010100, 5'd0};
    tbl[9]  = '{2'd0, 8'h00, 2'b11, 4'h0, 10'b1010101011, 10'b1010101011, 5'd0};
    tbl[10] = '{2'd3, 8'h00, 2'b00, 4'h8, isl_exp, isl_exp, 5'd0};
    tbl[11] = '{2'd1, 8'hFF, 2'b00, 4'h0, 10'b1000000000, 10'b1000000000, 5'b11000};
    tbl[12] = '{2'd1, 8'hFF, 2'b00, 4'h0, 10'b0011111111, 10'b0011111111, 5'b11110};
    tbl[13] = '{2'd1, 8'h55, 2'b00, 4'h0, 10'b0100110011, 10'b0100110011, 5'b11110};

    // Reset for a few cycles
    for (int i = 0; i < 3; i++) reset_step("por");

    // Table-driven vectors, inputs broadcast to every lane
    for (int i = 0; i < 14; i++) begin
      e = '0;
      for (int k = 0; k < CH; k++) begin
        e[10*k +: 10]       = ((k % 2) == 0) ? tbl[i].exp_even : tbl[i].exp_odd;
        e[CH*10 + 5*k +: 5] = tbl[i].exp_disp;
      end
      step(1'b0, tbl[i].mode, {CH{tbl[i].d}}, {CH{tbl[i].c}}, {CH{tbl[i].aux}}, e,
           $sformatf("vec%0d", i));
    end

    // One-cycle reset in the middle of a video run, then a fresh 0x00
    reset_step("pre_vid");
    model_step(2'd1, '0, '0, '0, "vid_a");
    model_step(2'd1, '0, '0, '0, "vid_b");
    model_step(2'd1, {CH{8'h3C}}, '0, '0, "vid_c");
    reset_step("mid_rst");
    e = {{CH{5'b11000}}, {CH{10'b0100000000}}};
    step(1'b0, 2'd1, '0, '0, '0, e, "post_rst");

    // Randomized run, video-heavy, independent data per lane
    reset_step("pre_rand");
    for (int i = 0; i < 400; i++) begin
      logic [1:0] m;
      m = ($urandom_range(0, 3) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
      model_step(m, CH*8'($urandom()), CH*2'($urandom()), CH*4'($urandom()),
                 $sformatf("rand%0d", i));
    end
    model_step(2'd0, '0, '0, '0, "drain0");
    model_step(2'd0, '0, '0, '0, "drain1");
    model_step(2'd0, '0, '0, '0, "drain2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_encode_nch.md
TMDS_ENCODE_NCH -- requirements
Module: tmds_encode_nch

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, giving the number of independent TMDS lanes (1..8).
REQ-002 SHALL have one clock and a synchronous, active-high reset. Ports SHALL be named clk and reset; this polarity and synchronicity are fixed.
REQ-003 clk  input  1  encoder clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_mode  input  2  period type: 0 = control, 1 = video data, 2 = video guard band, 3 = data island (TERC4). Shared by all lanes.
REQ-006 in_d  input  CHANNELS*8  video byte per lane; lane k uses [8k+7:8k].
REQ-007 in_c  input  CHANNELS*2  control bits {c1,c0} per lane; lane k uses [2k+1:2k].
REQ-008 in_aux  input  CHANNELS*4  TERC4 nibble per lane; lane k uses [4k+3:4k].
REQ-009 out_d  output  CHANNELS*10  encoded symbol per lane; lane k uses [10k+9:10k]. Bit 0 is transmitted first.
REQ-010 out_disparity  output  CHANNELS*5  signed running disparity per lane after the symbol on out_d; lane k uses [5k+4:5k].

Function
REQ-011 Latency SHALL be exactly 2 clk cycles from inputs sampled to out_d/out_disparity, with full throughput (one symbol per lane per cycle) and no stalls.
REQ-012 Stage 1 SHALL compute per lane: n1(in_d); q_m, using XNOR when n1>4 or (n1==4 and d[0]==0), else XOR; and n1/n0 of q_m[7:0].
REQ-013 Stage 2 SHALL apply DVI 1.0 DC balancing using a per-lane signed 5-bit counter cnt:
- invert when cnt==0 or n1==n0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
- otherwise invert iff (cnt>0 and n1>n0) or (cnt<0 and n0>n1).
- cnt update SHALL follow the DVI 1.0 formulas.
- cnt SHALL stay within -10..+10; no wrap is permitted.
REQ-014 Control mode SHALL emit (bits 9..0), per {c1,c0}: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
REQ-015 Guard band mode SHALL emit 1011001100 for even lane index k and 0100110011 for odd k.
REQ-016 Data island mode SHALL emit TERC4(in_aux) using this table, for nibble values 0..15 in order: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
REQ-017 In modes 0, 2 and 3, cnt SHALL be cleared to 0 and out_disparity SHALL read 0 for that symbol.
REQ-018 The first video symbol after any non-video symbol SHALL be encoded with cnt = 0.
REQ-019 in_mode may change on any cycle. Each symbol SHALL be encoded solely from the mode and data sampled with it, with no cross-symbol interaction other than cnt.
REQ-020 Lanes SHALL be fully independent; one lane's disparity SHALL never affect another lane.

Reset
REQ-021 While reset is high at a clk edge, every lane SHALL present out_d = 1101010100 and out_disparity = 0 from the next cycle, and cnt and all pipeline registers SHALL clear.
REQ-022 Reset asserted mid-stream SHALL flush both pipeline stages. Reset SHALL take priority over simultaneous input data.
REQ-023 The first input sampled after reset deasserts SHALL appear on out_d 2 cycles later. Until then, out_d SHALL hold the REQ-021 value.

Configuration
REQ-024 Macro TMDS_ENCODE_NCH_TERC4_EN, when defined, SHALL compile in the TERC4 table and data island mode per REQ-016.
REQ-025 When TMDS_ENCODE_NCH_TERC4_EN is undefined:
- in_mode 3 SHALL be treated as mode 0 (control codes from in_c);
- in_aux SHALL be ignored;
- no TERC4 logic SHALL be synthesised.

Verification
REQ-026 Reset, then mode 0 with c = 01 on lane 0 -> out_d lane 0 = 0010101011 two cycles later; out_disparity = 0.
REQ-027 From cnt = 0, mode 1 with d = 0x00 for 3 consecutive cycles -> out_d = 0100000000, 1111111111, 0100000000; out_disparity = -8, +2, -6.
REQ-028 Mode 2 with CHANNELS = 4 -> lanes 0..3 emit 1011001100, 0100110011, 1011001100, 0100110011.
REQ-029 Mode 1 run, then one mode 0 symbol, then mode 1 with d = 0x00 -> that video symbol = 0100000000, disparity -8 (cnt cleared).
REQ-030 With TERC4_EN defined, mode 3 with aux = 0x8 -> 1011001100. Without it, mode 3 with c = 00 -> 1101010100.
REQ-031 Reset asserted for 1 cycle mid-video -> out_d = 1101010100 and out_disparity = 0 next cycle; after deassertion, a fresh 0x00 yields 0100000000 and disparity -8.
